// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder/subtractor.
// Operation encoding, flag vector layout and carry-seed selection.
package cla_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_ADC = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_SBC = 2'b11;

    localparam int FLAG_C = 0;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 3;
    localparam int FLAG_W = 4;

    // ADC and SBC both take the caller's carry; SUB forces the +1.
    function automatic logic carry_seed(input logic [1:0] op,
                                        input logic       c_in);
        logic seed;
        seed = 1'b0;
        unique case (1'b1)
            op == OP_ADD: seed = 1'b0;
            op == OP_SUB: seed = 1'b1;
            default:      seed = c_in;
        endcase
        return seed;
    endfunction

endpackage

// File: rtl/cla_group.sv
// GRP-bit carry-lookahead group: sum, group propagate/generate, carry out.
// Every internal carry is a flat lookahead term of the group input carry.
module cla_group #(
    parameter int GRP = 4
) (
    input  logic [GRP-1:0] a,
    input  logic [GRP-1:0] b,
    input  logic           ci,
    output logic [GRP-1:0] s,
    output logic           p,
    output logic           g,
    output logic           co
);

    logic [GRP-1:0] bp;
    logic [GRP-1:0] bg;
    logic [GRP-1:0] c;
    logic           pr;

    assign bp = a ^ b;
    assign bg = a & b;

    always_comb begin
        c    = '0;
        g    = 1'b0;
        pr   = 1'b0;
        c[0] = ci;
        for (int i = 1; i < GRP; i++) begin
            c[i] = bg[i-1];
            pr   = bp[i-1];
            for (int j = i - 2; j >= 0; j--) begin
                c[i] = c[i] | (pr & bg[j]);
                pr   = pr & bp[j];
            end
            c[i] = c[i] | (pr & ci);
        end
        for (int i = 0; i < GRP; i++) begin
            g = bg[i] | (bp[i] & g);
        end
    end

    assign p  = &bp;
    assign s  = bp ^ c;
    assign co = g | (p & ci);

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined CLA adder/subtractor split into STAGES registered carry
// segments with skewed operands, deskewed sums and a valid/ready handshake.
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int GRP    = 4,
    parameter int STAGES = 4,
    parameter int TAG_W  = 4
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C_in,
    input  logic [1:0]       op,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             C_out,
    output logic             V,
    output logic             Z,
    output logic             N,
    output logic [TAG_W-1:0] tag_out
);

    localparam int SEG  = WIDTH / STAGES;
    localparam int NG   = SEG / GRP;
    localparam int LAST = STAGES - 1;

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             seed;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign b_eff    = op[1] ? ~B : B;
    assign seed     = carry_seed(op, C_in);

    for (genvar k = 0; k < STAGES; k++) begin : g_seg
        localparam int REM = WIDTH - (k + 1) * SEG;

        logic [SEG-1:0]       a_s;
        logic [SEG-1:0]       b_s;
        logic [SEG-1:0]       s_s;
        logic                 c_i;
        logic                 v_i;
        logic                 c_o;
        logic [TAG_W-1:0]     t_i;
        logic [(k+1)*SEG-1:0] s_d;
        logic [(k+1)*SEG-1:0] s_q;
        logic                 c_q;
        logic                 v_q;
        logic [TAG_W-1:0]     t_q;

        if (k == 0) begin : g_src
            assign a_s = A[SEG-1:0];
            assign b_s = b_eff[SEG-1:0];
            assign c_i = seed;
            assign v_i = in_valid;
            assign t_i = tag_in;
            assign s_d = s_s;
        end else begin : g_src
            assign a_s = g_seg[k-1].g_op.a_q[SEG-1:0];
            assign b_s = g_seg[k-1].g_op.b_q[SEG-1:0];
            assign c_i = g_seg[k-1].c_q;
            assign v_i = g_seg[k-1].v_q;
            assign t_i = g_seg[k-1].t_q;
            assign s_d = {s_s, g_seg[k-1].s_q};
        end

        // Operand bits for later segments ride along one stage per segment.
        if (k < LAST) begin : g_op
            logic [REM-1:0] a_d;
            logic [REM-1:0] b_d;
            logic [REM-1:0] a_q;
            logic [REM-1:0] b_q;

            if (k == 0) begin : g_ld
                assign a_d = A[WIDTH-1:SEG];
                assign b_d = b_eff[WIDTH-1:SEG];
            end else begin : g_ld
                assign a_d = g_seg[k-1].g_op.a_q[REM+SEG-1:SEG];
                assign b_d = g_seg[k-1].g_op.b_q[REM+SEG-1:SEG];
            end

            always_ff @(posedge clock or negedge clear_n) begin
                if (!clear_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end

        for (genvar j = 0; j < NG; j++) begin : g_grp
            logic       ci_g;
            logic       co_g;
            logic [1:0] pg_unused;

            if (j == 0) begin : g_ci
                assign ci_g = c_i;
            end else begin : g_ci
                assign ci_g = g_grp[j-1].co_g;
            end

            cla_group #(
                .GRP(GRP)
            ) u_grp (
                .a  (a_s[j*GRP +: GRP]),
                .b  (b_s[j*GRP +: GRP]),
                .ci (ci_g),
                .s  (s_s[j*GRP +: GRP]),
                .p  (pg_unused[1]),
                .g  (pg_unused[0]),
                .co (co_g)
            );
        end

        assign c_o = g_grp[NG-1].co_g;

        always_ff @(posedge clock or negedge clear_n) begin
            if (!clear_n) begin
                v_q <= 1'b0;
                t_q <= '0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (adv) begin
                v_q <= v_i;
                t_q <= t_i;
                c_q <= c_o;
                s_q <= s_d;
            end
        end

        if (k == LAST) begin : g_fl
            logic c_msb;
            logic ovf_q;

            // Carry into the MSB recovered from the MSB sum bit.
            assign c_msb = s_s[SEG-1] ^ a_s[SEG-1] ^ b_s[SEG-1];

            always_ff @(posedge clock or negedge clear_n) begin
                if (!clear_n) begin
                    ovf_q <= 1'b0;
                end else if (adv) begin
                    ovf_q <= c_msb ^ c_o;
                end
            end
        end
    end

    logic [FLAG_W-1:0] flags;

    assign S         = g_seg[LAST].s_q;
    assign out_valid = g_seg[LAST].v_q;
    assign tag_out   = g_seg[LAST].t_q;

    always_comb begin
        flags         = '0;
        flags[FLAG_C] = g_seg[LAST].c_q;
        flags[FLAG_V] = g_seg[LAST].g_fl.ovf_q;
        flags[FLAG_Z] = (S == '0);
        flags[FLAG_N] = S[WIDTH-1];
    end

    assign C_out = flags[FLAG_C];
    assign V     = flags[FLAG_V];
    assign Z     = flags[FLAG_Z];
    assign N     = flags[FLAG_N];

endmodule

// File: doc/cla_pipe_adder.md
# cla_pipe_adder

Parametrised, pipelined carry-lookahead adder/subtractor that extends the fixed 16-bit four-group CLA to any width. The datapath is split into a selectable number of registered carry segments, with a valid/ready handshake on each side. It sits in the ALU as the shared add/sub engine for ADD, SUB, ADDI and address-generation paths. It produces sum, carry/borrow, overflow, zero and negative flags, and carries a caller tag through for ordering checks.

## Interface
- WIDTH, 32: operand and result width; must be a multiple of STAGES*GRP.
- GRP, 4: bits per lookahead group (the cla_group instance width).
- STAGES, 4: number of pipeline segments; each segment covers WIDTH/STAGES bits; 1 ≤ STAGES ≤ WIDTH/GRP.
- TAG_W, 4: width of the pass-through tag.
- clock  in  1  rising-edge clock.
- clear_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts the beat this cycle.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- C_in  in  1  carry-in; used only by ADC and SBC.
- op  in  2  00 ADD (A+B), 01 ADC (A+B+C_in), 10 SUB (A+~B+1), 11 SBC (A+~B+C_in).
- tag_in  in  TAG_W  caller tag.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- S  out  WIDTH  sum/difference.
- C_out  out  1  carry out of the MSB. For SUB/SBC, 1 means no borrow.
- V  out  1  signed overflow: carry into MSB XOR carry out of MSB.
- Z  out  1  S == 0.
- N  out  1  S[WIDTH-1].
- tag_out  out  TAG_W  tag of the result.

## Operation
- Input stage: B' = op[1] ? ~B : B. The carry seed is 0 for ADD, C_in for ADC and SBC, and 1 for SUB.
- Segment k (0..STAGES-1) adds bits [k*SEG +: SEG] of A and B' with the registered carry from segment k-1. It uses SEG/GRP cla_group instances chained by group carry.
- Skew: operand slices for segment k are delayed k stages. Result slices from segment k are delayed STAGES-1-k stages, so all slices of one operation emerge together.
- Flags come from the final aligned S and from the last segment's carries. The carry into the MSB is taken inside the last segment.
- Each stage has a valid bit. Stages advance together when adv = !out_valid || out_ready.
- in_ready = adv. A beat is accepted when in_valid && in_ready.
- Bubbles are not collapsed: a stage with valid=0 still advances on adv.
- While adv=0, all stage registers hold, including data in bubble stages.
- Results leave in the same order they entered. The tag travels with its operation.
- After clear_n deasserts, all valid bits are 0 and the block is ready.

## Timing
- Latency: a beat accepted at edge t gives out_valid=1 after edge t+STAGES, assuming no stall. Throughput is 1 result per cycle with out_ready held high.
- Reset values: out_valid=0, S=0, C_out=0, V=0, Z=1, N=0, tag_out=0, all internal valid and carry registers 0. in_ready is 1 while clear_n=0.
- clear_n low mid-flight: all in-flight operations are discarded immediately, without waiting for a clock edge. No partial result is ever presented.
- Stall: out_valid && !out_ready holds S, flags and tag_out stable, and drives in_ready=0 in the same cycle (combinational).
- Simultaneous out_ready=1 and in_valid=1 with the pipe full: one result leaves and one operand enters on the same edge.
- STAGES=1: purely registered output, latency 1, no skew registers.
- Critical path per stage: SEG/GRP group-carry ripple plus one GRP-bit lookahead.

## Structure
- Shared package cla_pkg holds:
  - op encoding constants: OP_ADD, OP_ADC, OP_SUB, OP_SBC;
  - the flag index constants for V, Z, N and C.
- Sub-module cla_group: GRP-bit carry-lookahead with outputs S, group P, group G and C_out. Generalises the existing 4-bit CLA.
- Top module: generate loops over segments and groups; skew and deskew shift registers; valid pipeline; handshake logic.

## Test plan
All scenarios use WIDTH=32, STAGES=4, GRP=4.
- ADD 0xFFFFFFFF + 0x00000001 -> S=0x00000000, C_out=1, Z=1, V=0, N=0; out_valid exactly 4 cycles after acceptance.
- SUB 5 - 7 -> S=0xFFFFFFFE, C_out=0, N=1, V=0. SUB 7 - 5 -> S=0x00000002, C_out=1.
- ADD 0x7FFFFFFF + 0x00000001 -> S=0x80000000, V=1, N=1. SUB 0x80000000 - 1 -> S=0x7FFFFFFF, V=1.
- Carry across every segment boundary: ADC 0x00FFFFFF + 0x00000000 with C_in=1 -> S=0x01000000. SBC 0 - 0 with C_in=0 -> S=0xFFFFFFFF, C_out=0.
- Handshake: 8 back-to-back beats with tags 0..7; out_ready low for 3 cycles mid-stream.
  - Required: in_ready=0 during the stall and outputs stable.
  - Required: tags 0..7 emerge in order with no loss or duplication.
- Reset mid-flight: 3 beats in the pipe, clear_n pulsed low between edges.
  - Required: out_valid=0 before the next edge.
  - Required: no stale result appears after release; the next beat returns after 4 cycles.
